// File: rtl/cronometro_posse_param.sv
// ============================================================================
// Module   : cronometro_posse_param
// Brief    : Shot-clock countdown with full/short reload, buzzer and BCD out.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cronometro_posse_param #(
    parameter int WIDTH    = 5,
    parameter int FULL     = 24,
    parameter int SHORT    = 14,
    parameter int BUZZ_LEN = 3
) (
    input  logic             clock_in,
    input  logic             reset_n,
    input  logic             tick,
    input  logic             start,
    input  logic             stop,
    input  logic             load_full,
    input  logic             load_short,
    output logic [WIDTH-1:0] saida,
    output logic [3:0]       dezena,
    output logic [3:0]       unidade,
    output logic             running,
    output logic             expirou,
    output logic             buzzer
);

    localparam logic [WIDTH-1:0] c_full  = WIDTH'(FULL);
    localparam logic [WIDTH-1:0] c_short = WIDTH'(SHORT);
    localparam logic [WIDTH-1:0] c_one   = WIDTH'(1);
    localparam logic [3:0]       c_buzz  = 4'(BUZZ_LEN);

    typedef enum logic [1:0] {
        PARADO   = 2'd0,
        CONTANDO = 2'd1,
        ALARME   = 2'd2,
        ZERADO   = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] saida_q, saida_d;
    logic             expirou_q, expirou_d;
    logic             buzzer_q, buzzer_d;
    logic [3:0]       buzz_cnt_q, buzz_cnt_d;
    logic [31:0]      w_saida_ext;

    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= PARADO;
            saida_q    <= c_full;
            expirou_q  <= 1'b0;
            buzzer_q   <= 1'b0;
            buzz_cnt_q <= 4'd0;
        end else begin
            state_q    <= state_d;
            saida_q    <= saida_d;
            expirou_q  <= expirou_d;
            buzzer_q   <= buzzer_d;
            buzz_cnt_q <= buzz_cnt_d;
        end
    end

    // Strict priority: only the highest asserted command acts in a cycle.
    always_comb begin
        state_d    = state_q;
        saida_d    = saida_q;
        expirou_d  = expirou_q;
        buzzer_d   = buzzer_q;
        buzz_cnt_d = buzz_cnt_q;

        if (load_full) begin
            saida_d    = c_full;
            expirou_d  = 1'b0;
            buzzer_d   = 1'b0;
            buzz_cnt_d = 4'd0;
            state_d    = (state_q == CONTANDO) ? CONTANDO : PARADO;
        end else if (load_short) begin
            // The short reload may only raise the remaining time.
            if (saida_q < c_short) begin
                saida_d    = c_short;
                expirou_d  = 1'b0;
                buzzer_d   = 1'b0;
                buzz_cnt_d = 4'd0;
                state_d    = (state_q == CONTANDO) ? CONTANDO : PARADO;
            end
        end else if (stop) begin
            if (state_q == CONTANDO) begin
                state_d = PARADO;
            end
        end else if (start) begin
            if (state_q == PARADO) begin
                state_d = CONTANDO;
            end
        end else if (tick) begin
            case (state_q)
                CONTANDO: begin
                    if (saida_q > c_one) begin
                        saida_d = saida_q - c_one;
                    end else if (saida_q == c_one) begin
                        saida_d    = '0;
                        expirou_d  = 1'b1;
                        buzzer_d   = 1'b1;
                        buzz_cnt_d = c_buzz;
                        state_d    = ALARME;
                    end
                end
                ALARME: begin
                    buzz_cnt_d = buzz_cnt_q - 4'd1;
                    if (buzz_cnt_q == 4'd1) begin
                        buzzer_d = 1'b0;
                        state_d  = ZERADO;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign w_saida_ext = 32'(saida_q);
    assign saida       = saida_q;
    assign dezena      = 4'(w_saida_ext / 32'd10);
    assign unidade     = 4'(w_saida_ext % 32'd10);
    assign running     = (state_q == CONTANDO);
    assign expirou     = expirou_q;
    assign buzzer      = buzzer_q;

endmodule

`default_nettype wire

// File: doc/cronometro_posse_param.md
# cronometro_posse_param

Parametrised shot-clock countdown for the basketball scoreboard. Counts down whole seconds from a configurable full or short possession value on an external 1 Hz tick, with start/stop control and reset-to-full / reset-to-short commands. The short reset only raises a lower remaining time. On expiry it drives a buzzer for a programmable number of ticks. It sits between the seconds prescaler and the 7-segment display decoders, which take its BCD digit outputs.

## Interface
- WIDTH, 5: counter width in bits; FULL < 2^WIDTH.
- FULL, 24: full possession value in seconds; 1..99.
- SHORT, 14: short possession value in seconds; 1..FULL.
- BUZZ_LEN, 3: buzzer duration in ticks; ≥1, fits in 4 bits.

Ports:
- clock_in  in  1  system clock; all logic on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- tick  in  1  one-cycle pulse per second from the prescaler.
- start  in  1  one-cycle pulse: run.
- stop  in  1  one-cycle pulse: pause.
- load_full  in  1  one-cycle pulse: counter ← FULL.
- load_short  in  1  one-cycle pulse: counter ← SHORT if counter < SHORT.
- saida  out  WIDTH  current count, binary.
- dezena  out  4  BCD tens digit of saida.
- unidade  out  4  BCD units digit of saida.
- running  out  1  high while in CONTANDO.
- expirou  out  1  high from expiry until the next load.
- buzzer  out  1  high during ALARME.

## Operation
- States:
  - PARADO: stopped, count held.
  - CONTANDO: counting.
  - ALARME: count is 0, buzzer on.
  - ZERADO: count is 0, buzzer off.
- Reset (async, reset_n=0) sets: state PARADO, saida=FULL, buzzer=0, expirou=0, running=0, buzz_cnt=0.
- Per-cycle command priority: load_full > load_short > stop > start > tick. Only the highest-priority asserted input acts; the others are ignored that cycle.
- load_full:
  - saida ← FULL; expirou ← 0; buzzer ← 0.
  - CONTANDO stays CONTANDO. PARADO, ALARME and ZERADO go to PARADO.
- load_short:
  - If saida < SHORT: saida ← SHORT, expirou ← 0, buzzer ← 0, and state changes exactly as for load_full.
  - Otherwise no change at all (state, count and flags held).
- stop: CONTANDO → PARADO. Ignored in every other state.
- start: PARADO → CONTANDO. Ignored in ALARME and ZERADO, and a no-op in CONTANDO.
- tick in CONTANDO:
  - saida > 1: saida ← saida − 1.
  - saida = 1: saida ← 0, expirou ← 1, buzzer ← 1, buzz_cnt ← BUZZ_LEN, state ALARME.
- tick in ALARME:
  - buzz_cnt ← buzz_cnt − 1.
  - If buzz_cnt = 1: buzzer ← 0, state ZERADO.
- tick in PARADO or ZERADO: ignored.
- No wrap-around: the count never goes below 0 and never decrements in ALARME or ZERADO.
- dezena = saida / 10 and unidade = saida % 10, combinational from the registered saida. Values are always ≤ 99.

## Timing
- All register updates happen on the rising clock_in edge where the command is sampled. saida, running, expirou and buzzer change 1 cycle after the command or tick.
- BCD outputs have zero added latency relative to saida.
- buzzer is high for exactly BUZZ_LEN ticks:
  - It rises the cycle after the tick that takes saida from 1 to 0.
  - It falls the cycle after the BUZZ_LEN-th subsequent tick.
- Simultaneous events:
  - start+tick: run begins, no decrement that cycle.
  - stop+tick: pause, no decrement.
  - load_*+tick: the load wins.
  - load_full+load_short: FULL is loaded.
- reset_n asserted mid-count or mid-alarm forces reset values immediately, without waiting for a clock edge. Release is synchronous to the next edge.
- A tick held high for multiple cycles counts once per cycle. Upstream guarantees single-cycle pulses.

## Test plan
- Reset then start, then 3 ticks → saida 24, 23, 22, 21. dezena/unidade show 2/1. running=1.
- Count from 3, 1 tick after the value reaches 1 → saida=0, expirou=1, buzzer=1 for exactly 3 ticks, then ZERADO with buzzer=0. The next 2 ticks leave saida at 0.
- At saida=20 running, load_short → unchanged at 20. At saida=9 running, load_short → saida=14 and still running.
- start and tick in the same cycle from PARADO at 24 → saida stays 24. The next tick gives 23. stop+tick at 23 → holds 23, running=0.
- During ALARME with buzz_cnt=2, load_full → saida=24, buzzer=0, expirou=0, PARADO. Then start+tick gives normal counting.
- reset_n pulsed low mid-alarm (between clock edges) → buzzer and expirou drop immediately and saida=24, before the next clock edge.
